// File: rtl/register_bus_reader_pkg.sv
// ============================================================================
//  Module      : register_bus_reader_pkg
//  Description : Shared definitions for the register bus reader.
//                - Sequencer state encoding.
//                - All-ones idle chip-select pattern.
//                  It is sliced to NrOfSlots by each user.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package register_bus_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Wide enough for the largest supported ring (16 slots).
    localparam logic [15:0] CS_IDLE = 16'hFFFF;

endpackage

`default_nettype wire

// File: rtl/register_bus_reader_if.sv
// ============================================================================
//  Module      : register_bus_reader_if
//  Description : Request / bus / response signals of the register bus reader.
//                - slave  : the reader itself.
//                - master : the requesting controller together with the
//                           bus-attached slots.
//                Ports    : ClockEnable, Tick, ReqValid, ReqAddr, ReqBurst,
//                           ReqReady, Abort, Bus, Cs, RspValid, RspData,
//                           RspAddr, RspLast, RspErr, RspReady, Busy
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface register_bus_reader_if #(
    parameter int NrOfBits  = 8,
    parameter int NrOfSlots = 4,
    parameter int AddrBits  = 2
) ();

    logic                 ClockEnable;
    logic                 Tick;
    logic                 ReqValid;
    logic [AddrBits-1:0]  ReqAddr;
    logic                 ReqBurst;
    logic                 ReqReady;
    logic                 Abort;
    logic [NrOfBits-1:0]  Bus;
    logic [NrOfSlots-1:0] Cs;
    logic                 RspValid;
    logic [NrOfBits-1:0]  RspData;
    logic [AddrBits-1:0]  RspAddr;
    logic                 RspLast;
    logic                 RspErr;
    logic                 RspReady;
    logic                 Busy;

    modport slave (
        input  ClockEnable, Tick, ReqValid, ReqAddr, ReqBurst, Abort, Bus, RspReady,
        output ReqReady, Cs, RspValid, RspData, RspAddr, RspLast, RspErr, Busy
    );

    modport master (
        output ClockEnable, Tick, ReqValid, ReqAddr, ReqBurst, Abort, Bus, RspReady,
        input  ReqReady, Cs, RspValid, RspData, RspAddr, RspLast, RspErr, Busy
    );

endinterface

`default_nettype wire

// File: rtl/register_bus_reader_slot_decoder.sv
// ============================================================================
//  Module      : reader_slot_decoder
//  Description : Combinational active-low one-hot slot decoder.
//                - With i_en low the output is all ones.
//                - Addresses that do not match any slot also give all ones.
//                Ports    : i_addr, i_en, o_cs_n
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reader_slot_decoder #(
    parameter int NrOfSlots = 4,
    parameter int AddrBits  = 2
) (
    input  wire logic [AddrBits-1:0]  i_addr,
    input  wire logic                 i_en,
    output logic      [NrOfSlots-1:0] o_cs_n
);

    for (genvar g = 0; g < NrOfSlots; g++) begin : g_slot
        assign o_cs_n[g] = ~(i_en && (i_addr == AddrBits'(g)));
    end

endmodule

`default_nettype wire

// File: rtl/register_bus_reader.sv
// ============================================================================
//  Module      : register_bus_reader
//  Description : Read sequencer for the shared tri-state register bus.
//                - Selects one slot (Cs active low).
//                - Waits SettleCycles qualified steps, then samples Bus.
//                - Returns the data over a valid/ready response port.
//                - Supports single reads and full-ring burst scans.
//                Ports    : Clock, Reset (async, active high),
//                           bus_if (register_bus_reader_if.slave)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_bus_reader
    import register_bus_reader_pkg::*;
#(
    parameter int NrOfBits     = 8,
    parameter int NrOfSlots    = 4,
    parameter int AddrBits     = 2,
    parameter int SettleCycles = 1
) (
    input  wire logic             Clock,
    input  wire logic             Reset,
    register_bus_reader_if.slave  bus_if
);

    localparam logic [NrOfSlots-1:0] c_cs_idle     = CS_IDLE[NrOfSlots-1:0];
    localparam logic [4:0]           c_slots       = 5'(NrOfSlots);
    localparam logic [3:0]           c_settle_last = 4'(SettleCycles - 1);
    localparam logic [AddrBits-1:0]  c_last_slot   = AddrBits'(NrOfSlots - 1);
    localparam int unsigned          c_nslots      = NrOfSlots;

    state_t                r_state;
    logic [NrOfSlots-1:0]  r_cs;
    logic                  r_rsp_valid;
    logic [NrOfBits-1:0]   r_rsp_data;
    logic [AddrBits-1:0]   r_rsp_addr;
    logic                  r_rsp_last;
    logic                  r_rsp_err;
    logic                  r_busy;
    logic                  r_req_ready;
    logic [AddrBits-1:0]   r_cur;
    logic [4:0]            r_remaining;
    logic [3:0]            r_settle;

    logic                  w_step;
    logic                  w_req_in_range;
    logic [AddrBits-1:0]   w_next_cur;
    logic [AddrBits-1:0]   w_dec_addr;
    logic                  w_dec_en;
    logic [NrOfSlots-1:0]  w_cs_dec;

    assign w_step         = bus_if.ClockEnable & bus_if.Tick;
    assign w_req_in_range = 32'(bus_if.ReqAddr) < c_nslots;
    assign w_next_cur     = (r_cur == c_last_slot) ? '0 : r_cur + 1'b1;

    // One decoder serves both select points: the requested slot while idle,
    // the following ring slot while a burst response is outstanding.
    assign w_dec_addr = (r_state == ST_IDLE) ? bus_if.ReqAddr : w_next_cur;
    assign w_dec_en   = (r_state == ST_IDLE) ? w_req_in_range : 1'b1;

    reader_slot_decoder #(
        .NrOfSlots (NrOfSlots),
        .AddrBits  (AddrBits)
    ) u_decoder (
        .i_addr (w_dec_addr),
        .i_en   (w_dec_en),
        .o_cs_n (w_cs_dec)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_cs        <= c_cs_idle;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_addr  <= '0;
            r_rsp_last  <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
            r_cur       <= '0;
            r_remaining <= '0;
            r_settle    <= '0;
        end else if (bus_if.Abort) begin
            // Abort wins over acceptance and the handshake. RspData is kept.
            r_state     <= ST_IDLE;
            r_cs        <= c_cs_idle;
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_step && bus_if.ReqValid) begin
                        r_cur       <= bus_if.ReqAddr;
                        r_remaining <= bus_if.ReqBurst ? c_slots : 5'd1;
                        r_settle    <= '0;
                        r_busy      <= 1'b1;
                        r_req_ready <= 1'b0;
                        if (w_req_in_range) begin
                            r_cs    <= w_cs_dec;
                            r_state <= ST_SELECT;
                        end else begin
                            // Out-of-range slot: one error response, no select.
                            r_rsp_data  <= '0;
                            r_rsp_addr  <= bus_if.ReqAddr;
                            r_rsp_last  <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end
                    end
                end

                ST_SELECT: begin
                    if (w_step) begin
                        if (r_settle == c_settle_last) begin
                            r_rsp_data  <= bus_if.Bus;
                            r_rsp_addr  <= r_cur;
                            r_rsp_last  <= (r_remaining == 5'd1);
                            r_rsp_err   <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_cs        <= c_cs_idle;
                            r_state     <= ST_RESP;
                        end else begin
                            r_settle <= r_settle + 4'd1;
                        end
                    end
                end

                ST_RESP: begin
                    // Handshake is not step-gated. Cs stays idle for the whole
                    // response, giving break-before-make between slots.
                    if (r_rsp_valid && bus_if.RspReady) begin
                        r_rsp_valid <= 1'b0;
                        if (r_rsp_last) begin
                            r_state     <= ST_IDLE;
                            r_busy      <= 1'b0;
                            r_req_ready <= 1'b1;
                        end else begin
                            r_cur       <= w_next_cur;
                            r_remaining <= r_remaining - 5'd1;
                            r_settle    <= '0;
                            r_cs        <= w_cs_dec;
                            r_state     <= ST_SELECT;
                        end
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_cs        <= c_cs_idle;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus_if.Cs       = r_cs;
    assign bus_if.RspValid = r_rsp_valid;
    assign bus_if.RspData  = r_rsp_data;
    assign bus_if.RspAddr  = r_rsp_addr;
    assign bus_if.RspLast  = r_rsp_last;
    assign bus_if.RspErr   = r_rsp_err;
    assign bus_if.Busy     = r_busy;
    assign bus_if.ReqReady = r_req_ready;

endmodule

`default_nettype wire

// File: tb/tb_register_bus_reader.sv
// ============================================================================
//  Module      : tb_register_bus_reader
//  Description : Self-checking bench for register_bus_reader.
//                - DUT A: 4 slots, SettleCycles = 1.
//                - DUT B: 3 slots, SettleCycles = 3, Tick every other clock.
//                Responses are checked against a queue of expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_bus_reader;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] addr;
        logic       last;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    register_bus_reader_if #(.NrOfBits(8), .NrOfSlots(4), .AddrBits(2)) bus_a ();
    register_bus_reader_if #(.NrOfBits(8), .NrOfSlots(3), .AddrBits(2)) bus_b ();

    register_bus_reader #(.NrOfBits(8), .NrOfSlots(4), .AddrBits(2), .SettleCycles(1)) u_dut_a (
        .Clock  (clk),
        .Reset  (rst),
        .bus_if (bus_a)
    );

    register_bus_reader #(.NrOfBits(8), .NrOfSlots(3), .AddrBits(2), .SettleCycles(3)) u_dut_b (
        .Clock  (clk),
        .Reset  (rst),
        .bus_if (bus_b)
    );

    // Bus-attached slot models: a slot drives only while its select is low.
    logic [7:0] slot_a [4];
    logic [7:0] slot_b [3];

    always_comb begin
        bus_a.Bus = 8'h00;
        for (int i = 0; i < 4; i++) if (!bus_a.Cs[i]) bus_a.Bus = slot_a[i];
    end

    always_comb begin
        bus_b.Bus = 8'h00;
        for (int i = 0; i < 3; i++) if (!bus_b.Cs[i]) bus_b.Bus = slot_b[i];
    end

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    int   hs_a = 0;
    logic       prev_stall [2] = '{1'b0, 1'b0};
    logic [11:0] prev_rsp  [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic mon_cycle(input int id, input logic v, input logic r, input logic [7:0] d,
                             input logic [1:0] a, input logic l, input logic e,
                             input logic [3:0] cs);
        exp_t x;
        check("cs_single_low", 32'($countones(~cs) <= 1), 32'd1);
        if (v) check("cs_idle_in_resp", 32'(cs), 32'hF);
        if (prev_stall[id] && v) check("rsp_stable", 32'({d, a, l, e}), 32'(prev_rsp[id]));
        prev_stall[id] = v && !r;
        prev_rsp[id]   = {d, a, l, e};
        if (v && r) begin
            if (id == 0) hs_a++;
            if ((id == 0 && q_a.size() == 0) || (id == 1 && q_b.size() == 0)) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                x = (id == 0) ? q_a.pop_front() : q_b.pop_front();
                check("rsp_data", 32'(d), 32'(x.data));
                check("rsp_addr", 32'(a), 32'(x.addr));
                check("rsp_last", 32'(l), 32'(x.last));
                check("rsp_err",  32'(e), 32'(x.err));
            end
        end
    endtask

    always @(negedge clk) begin
        mon_cycle(0, bus_a.RspValid, bus_a.RspReady, bus_a.RspData, bus_a.RspAddr,
                  bus_a.RspLast, bus_a.RspErr, bus_a.Cs);
        mon_cycle(1, bus_b.RspValid, bus_b.RspReady, bus_b.RspData, bus_b.RspAddr,
                  bus_b.RspLast, bus_b.RspErr, {1'b1, bus_b.Cs});
    end

    // DUT B sees a qualified step only on every other clock.
    initial begin
        bus_b.Tick = 1'b0;
        forever begin
            @(posedge clk);
            #1 bus_b.Tick = ~bus_b.Tick;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int id, input int lim);
        int n = 0;
        while (((id == 0) ? bus_a.Busy : bus_b.Busy) && n < lim) begin
            step();
            n++;
        end
        check("wait_idle", 32'((id == 0) ? bus_a.Busy : bus_b.Busy), 32'd0);
    endtask

    task automatic wait_valid_a(input int lim);
        int n = 0;
        while (!bus_a.RspValid && n < lim) begin
            step();
            n++;
        end
        check("wait_valid", 32'(bus_a.RspValid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t x;
        int   n;
        int   cnt;

        bus_a.ClockEnable = 1'b1; bus_a.Tick = 1'b1; bus_a.ReqValid = 1'b0;
        bus_a.ReqAddr = '0; bus_a.ReqBurst = 1'b0; bus_a.Abort = 1'b0; bus_a.RspReady = 1'b1;
        bus_b.ClockEnable = 1'b1; bus_b.ReqValid = 1'b0;
        bus_b.ReqAddr = '0; bus_b.ReqBurst = 1'b0; bus_b.Abort = 1'b0; bus_b.RspReady = 1'b1;
        slot_a = '{8'h11, 8'h22, 8'hA5, 8'h44};
        slot_b = '{8'h5A, 8'h66, 8'h77};

        step();
        step();
        // Reset values.
        check("rst_cs",    32'(bus_a.Cs),       32'hF);
        check("rst_valid", 32'(bus_a.RspValid), 32'd0);
        check("rst_data",  32'(bus_a.RspData),  32'd0);
        check("rst_busy",  32'(bus_a.Busy),     32'd0);
        check("rst_ready", 32'(bus_a.ReqReady), 32'd1);
        check("rst_cs_b",  32'(bus_b.Cs),       32'h7);
        rst = 1'b0;
        step();

        // Single read of slot 2.
        bus_a.ReqValid = 1'b1; bus_a.ReqAddr = 2'd2; bus_a.ReqBurst = 1'b0;
        q_a.push_back('{8'hA5, 2'd2, 1'b1, 1'b0});
        step();
        bus_a.ReqValid = 1'b0;
        check("single_cs",    32'(bus_a.Cs),       32'b1011);
        check("single_busy",  32'(bus_a.Busy),     32'd1);
        check("single_rdy",   32'(bus_a.ReqReady), 32'd0);
        step();
        check("single_cs_off", 32'(bus_a.Cs),       32'hF);
        check("single_valid",  32'(bus_a.RspValid), 32'd1);
        wait_idle(0, 10);

        // Burst from slot 3 with wrap, stalling the second response.
        slot_a = '{8'h11, 8'h22, 8'h33, 8'h44};
        hs_a = 0;
        bus_a.ReqValid = 1'b1; bus_a.ReqAddr = 2'd3; bus_a.ReqBurst = 1'b1;
        q_a.push_back('{8'h44, 2'd3, 1'b0, 1'b0});
        q_a.push_back('{8'h11, 2'd0, 1'b0, 1'b0});
        q_a.push_back('{8'h22, 2'd1, 1'b0, 1'b0});
        q_a.push_back('{8'h33, 2'd2, 1'b1, 1'b0});
        step();
        bus_a.ReqValid = 1'b0;
        n = 0;
        while (hs_a < 1 && n < 20) begin
            step();
            n++;
        end
        check("burst_first_hs", 32'(hs_a), 32'd1);
        bus_a.RspReady = 1'b0;
        wait_valid_a(10);
        for (int i = 0; i < 5; i++) step();
        bus_a.RspReady = 1'b1;
        wait_idle(0, 30);
        check("burst_hs_count", 32'(hs_a), 32'd4);

        // Abort during SELECT of a burst.
        bus_a.ReqValid = 1'b1; bus_a.ReqAddr = 2'd0; bus_a.ReqBurst = 1'b1;
        step();
        bus_a.ReqValid = 1'b0;
        check("abort_pre_cs", 32'(bus_a.Cs), 32'b1110);
        bus_a.Abort = 1'b1;
        step();
        bus_a.Abort = 1'b0;
        check("abort_cs",    32'(bus_a.Cs),       32'hF);
        check("abort_busy",  32'(bus_a.Busy),     32'd0);
        check("abort_rdy",   32'(bus_a.ReqReady), 32'd1);
        check("abort_valid", 32'(bus_a.RspValid), 32'd0);
        for (int i = 0; i < 3; i++) step();

        // Asynchronous reset while a response is pending.
        bus_a.RspReady = 1'b0;
        bus_a.ReqValid = 1'b1; bus_a.ReqAddr = 2'd1; bus_a.ReqBurst = 1'b0;
        q_a.push_back('{8'h22, 2'd1, 1'b1, 1'b0});
        step();
        bus_a.ReqValid = 1'b0;
        wait_valid_a(10);
        x = q_a.pop_front();
        check("pre_rst_data", 32'(bus_a.RspData), 32'(x.data));
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_cs",    32'(bus_a.Cs),       32'hF);
        check("arst_valid", 32'(bus_a.RspValid), 32'd0);
        check("arst_data",  32'(bus_a.RspData),  32'd0);
        check("arst_addr",  32'(bus_a.RspAddr),  32'd0);
        check("arst_last",  32'(bus_a.RspLast),  32'd0);
        check("arst_busy",  32'(bus_a.Busy),     32'd0);
        step();
        rst = 1'b0;
        bus_a.RspReady = 1'b1;
        bus_a.ReqValid = 1'b1; bus_a.ReqAddr = 2'd0; bus_a.ReqBurst = 1'b0;
        q_a.push_back('{8'h11, 2'd0, 1'b1, 1'b0});
        step();
        bus_a.ReqValid = 1'b0;
        wait_idle(0, 10);

        // Step gating on DUT B: Cs low for 3 steps = 6 clocks.
        bus_b.ReqValid = 1'b1; bus_b.ReqAddr = 2'd1; bus_b.ReqBurst = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (bus_b.Cs == 3'b111 && n < 10);
        bus_b.ReqValid = 1'b0;
        check("gate_cs", 32'(bus_b.Cs), 32'b101);
        slot_b[1] = 8'hC3;
        q_b.push_back('{8'hC3, 2'd1, 1'b1, 1'b0});
        cnt = 1;
        while (bus_b.Cs != 3'b111 && cnt < 20) begin
            step();
            if (bus_b.Cs != 3'b111) cnt++;
        end
        check("gate_cs_low_clocks", 32'(cnt), 32'd6);
        wait_idle(1, 20);

        // Out-of-range slot on DUT B.
        bus_b.ReqValid = 1'b1; bus_b.ReqAddr = 2'd3; bus_b.ReqBurst = 1'b1;
        q_b.push_back('{8'h00, 2'd3, 1'b1, 1'b1});
        n = 0;
        do begin
            step();
            n++;
        end while (!bus_b.Busy && n < 10);
        bus_b.ReqValid = 1'b0;
        check("oor_busy", 32'(bus_b.Busy), 32'd1);
        check("oor_cs",   32'(bus_b.Cs),   32'h7);
        wait_idle(1, 20);

        step();
        check("q_a_empty", 32'(q_a.size()), 32'd0);
        check("q_b_empty", 32'(q_b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
